// File: rtl/fetch_unit_if.sv
// Byte-wide request/acknowledge memory read port used by the fetch stage.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 64
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              mem_ack;
   logic              mem_err;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rdata,
      input  mem_ack,
      input  mem_err
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rdata,
      output mem_ack,
      output mem_err
   );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial Y86-64 fetch stage: reads 1-10 instruction bytes over a
// req/ack byte port, splits them into icode/ifun/rA/rB/valC, computes valP
// and reports AOK/HLT/ADR/INS status with a one-cycle done pulse.
module fetch_unit #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned MAX_LEN = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc,
   fetch_unit_if.master      mem,
   output logic              busy,
   output logic              done,
   output logic [3:0]        icode,
   output logic [3:0]        ifun,
   output logic [3:0]        rA,
   output logic [3:0]        rB,
   output logic [63:0]       valC,
   output logic [ADDR_W-1:0] valP,
   output logic [1:0]        status
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   localparam logic [1:0] ST_AOK = 2'd0;
   localparam logic [1:0] ST_HLT = 2'd1;
   localparam logic [1:0] ST_ADR = 2'd2;
   localparam logic [1:0] ST_INS = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DONE
   } state_t;

   // Instruction length in bytes, keyed by icode (unknown codes treated as 1).
   function automatic logic [CNT_W-1:0] instr_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       instr_len = CNT_W'(1);
         4'h2, 4'h6, 4'hA, 4'hB: instr_len = CNT_W'(2);
         4'h7, 4'h8:             instr_len = CNT_W'(9);
         4'h3, 4'h4, 4'h5:       instr_len = CNT_W'(10);
         default:                instr_len = CNT_W'(1);
      endcase
   endfunction

   // Legal icode/ifun combinations.
   function automatic logic instr_valid(input logic [3:0] ic, input logic [3:0] fn);
      case (ic)
         4'h2, 4'h7: instr_valid = (fn <= 4'd6);
         4'h6:       instr_valid = (fn <= 4'd3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                     instr_valid = (fn == 4'd0);
         default:    instr_valid = 1'b0;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [3:0]          icode_q, icode_d;
   logic [3:0]          ifun_q, ifun_d;
   logic [3:0]          ra_q, ra_d;
   logic [3:0]          rb_q, rb_d;
   logic [63:0]         valc_q, valc_d;
   logic [ADDR_W-1:0]   valp_q, valp_d;
   logic [1:0]          status_q, status_d;
   logic                done_q, done_d;

   logic                accept;
   logic                last_byte;
   logic [CNT_W-1:0]    b0_len;
   logic                b0_ok;
   logic                has_regs;
   logic [CNT_W-1:0]    vidx;
   logic [ADDR_W-1:0]   next_pc;

   assign accept   = (state_q == S_FETCH) && mem.mem_ack;
   assign b0_len   = instr_len(mem.mem_rdata[7:4]);
   assign b0_ok    = instr_valid(mem.mem_rdata[7:4], mem.mem_rdata[3:0]);
   assign has_regs = (len_q == CNT_W'(2)) || (len_q == CNT_W'(10));
   assign next_pc  = pc_q + ADDR_W'(k_q) + ADDR_W'(1);

   // valC byte slot: byte k lands at k-1 (jxx/call) or k-2 (register byte first)
   assign vidx     = k_q - (has_regs ? CNT_W'(2) : CNT_W'(1));

   // Decide whether the byte being accepted this cycle ends the fetch.
   always_comb begin
      last_byte = 1'b0;
      if (accept) begin
         if (mem.mem_err) begin
            last_byte = 1'b1;
         end else if (k_q == '0) begin
            last_byte = !b0_ok || (b0_len == CNT_W'(1));
         end else begin
            last_byte = ((k_q + CNT_W'(1)) == len_q);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)     state_d = S_FETCH;
         S_FETCH: if (last_byte) state_d = S_DONE;
         S_DONE:                 state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request held through FETCH, address tracks pc+k.
   always_comb begin
      mem.mem_req  = (state_q == S_FETCH);
      mem.mem_addr = pc_q + ADDR_W'(k_q);
      busy         = (state_q != S_IDLE);
   end

   // Datapath: latch pc on start, capture bytes on ack, finalise valP/status.
   always_comb begin
      pc_d     = pc_q;
      k_d      = k_q;
      len_d    = len_q;
      icode_d  = icode_q;
      ifun_d   = ifun_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      valc_d   = valc_q;
      valp_d   = valp_q;
      status_d = status_q;
      done_d   = (state_q == S_DONE);

      if ((state_q == S_IDLE) && start) begin
         pc_d     = pc;
         k_d      = '0;
         len_d    = '0;
         icode_d  = '0;
         ifun_d   = '0;
         ra_d     = '1;
         rb_d     = '1;
         valc_d   = '0;
         status_d = ST_AOK;
      end else if (accept) begin
         if (mem.mem_err) begin
            // failing byte is not captured but still counts toward valP
            status_d = ST_ADR;
            valp_d   = next_pc;
         end else if (k_q == '0) begin
            icode_d = mem.mem_rdata[7:4];
            ifun_d  = mem.mem_rdata[3:0];
            len_d   = b0_len;
            if (!b0_ok) begin
               status_d = ST_INS;
               valp_d   = next_pc;
            end else if (b0_len == CNT_W'(1)) begin
               status_d = (mem.mem_rdata[7:4] == 4'h0) ? ST_HLT : ST_AOK;
               valp_d   = next_pc;
            end else begin
               k_d = CNT_W'(1);
            end
         end else begin
            if (has_regs && (k_q == CNT_W'(1))) begin
               ra_d = mem.mem_rdata[7:4];
               rb_d = mem.mem_rdata[3:0];
            end else begin
               valc_d = valc_q | ({56'd0, mem.mem_rdata} << {vidx, 3'b000});
            end
            if (last_byte) begin
               status_d = ST_AOK;
               valp_d   = next_pc;
            end else begin
               k_d = k_q + CNT_W'(1);
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= '0;
         k_q      <= '0;
         len_q    <= '0;
         icode_q  <= '0;
         ifun_q   <= '0;
         ra_q     <= '1;
         rb_q     <= '1;
         valc_q   <= '0;
         valp_q   <= '0;
         status_q <= ST_AOK;
         done_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         k_q      <= k_d;
         len_q    <= len_d;
         icode_q  <= icode_d;
         ifun_q   <= ifun_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         valc_q   <= valc_d;
         valp_q   <= valp_d;
         status_q <= status_d;
         done_q   <= done_d;
      end
   end

   assign done   = done_q;
   assign icode  = icode_q;
   assign ifun   = ifun_q;
   assign rA     = ra_q;
   assign rB     = rb_q;
   assign valC   = valc_q;
   assign valP   = valp_q;
   assign status = status_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte-memory responder with configurable
// wait states and error injection, vector table plus reset/start corner cases.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] pc;
   logic        busy, done;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic [1:0]  status;

   fetch_unit_if #(.ADDR_W(64)) bus ();

   fetch_unit #(.ADDR_W(64), .MAX_LEN(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .pc     (pc),
      .mem    (bus),
      .busy   (busy),
      .done   (done),
      .icode  (icode),
      .ifun   (ifun),
      .rA     (rA),
      .rB     (rB),
      .valC   (valC),
      .valP   (valP),
      .status (status)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory image and responder configuration
   logic [7:0]  img [logic [63:0]];
   int          wait_cyc = 0;
   bit          err_en = 1'b0;
   logic [63:0] err_addr = '0;
   int          n_acks = 0;
   int          hold_viol = 0;
   logic [63:0] acked_addr [256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory responder: answers on the negedge after wait_cyc idle cycles.
   initial begin
      int wcnt;
      logic [63:0] wait_addr;
      wcnt = 0;
      wait_addr = '0;
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.mem_req) begin
            if (wcnt > 0 && bus.mem_addr != wait_addr) hold_viol++;
            if (wcnt == wait_cyc) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = img.exists(bus.mem_addr) ? img[bus.mem_addr] : 8'h00;
               bus.mem_err   = err_en && (bus.mem_addr == err_addr);
               acked_addr[n_acks & 255] = bus.mem_addr;
               n_acks++;
               wcnt = 0;
            end else begin
               if (wcnt == 0) wait_addr = bus.mem_addr;
               bus.mem_ack = 1'b0;
               bus.mem_err = 1'b0;
               wcnt++;
            end
         end else begin
            bus.mem_ack = 1'b0;
            bus.mem_err = 1'b0;
            wcnt = 0;
         end
      end
   end

   typedef struct {
      logic [63:0] pc;
      logic [79:0] code;   // byte i at code[8*i +: 8]
      int          nb;
      int          wt;
      bit          erre;
      int          erri;
      int          lat;
      int          nacks;
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp;
      logic [1:0]  st;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic load_img(input logic [63:0] base, input logic [79:0] code, input int nb);
      img.delete();
      for (int i = 0; i < nb; i++) img[base + 64'(i)] = code[8*i +: 8];
   endtask

   // Pulse start with the given pc and count edges until done (bounded).
   task automatic run_fetch(input logic [63:0] p, output int lat);
      bit seen;
      @(negedge clk);
      pc = p;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(posedge clk);
         #1 lat++;
         if (done) seen = 1'b1;
      end
      chk("done_timeout", 64'(seen), 64'd1);
   endtask

   initial begin
      int lat, base, hv0, n;
      rst = 1'b1;
      start = 1'b0;
      pc = '0;

      //            pc                     code                          nb wt er ei lat acks ic    if    ra    rb    valc                   valp                   st
      vecs[0]  = '{64'h100, 80'h1122334455667788F330, 10, 0, 0, 0, 11, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h10A, 2'd0};
      vecs[1]  = '{64'h40,  80'h00,                    1, 0, 0, 0,  2,  1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41,  2'd1};
      vecs[2]  = '{64'h200, 80'h080706050403020174,    9, 2, 0, 0, 28,  9, 4'h7, 4'h4, 4'hF, 4'hF, 64'h0807060504030201, 64'h209, 2'd0};
      vecs[3]  = '{64'h300, 80'hC0,                    1, 0, 0, 0,  2,  1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 2'd3};
      vecs[4]  = '{64'h310, 80'h1262,                  2, 0, 0, 0,  3,  2, 4'h6, 4'h2, 4'h1, 4'h2, 64'h0, 64'h312, 2'd0};
      vecs[5]  = '{64'h320, 80'h1264,                  2, 0, 0, 0,  2,  1, 4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h321, 2'd3};
      vecs[6]  = '{64'h330, 80'h12F2,                  2, 0, 0, 0,  2,  1, 4'hF, 4'h2, 4'hF, 4'hF, 64'h0, 64'h331, 2'd3};
      vecs[7]  = '{64'h400, 80'h0807060504030201AB40, 10, 0, 1, 5,  7,  6, 4'h4, 4'h0, 4'hA, 4'hB, 64'h030201, 64'h406, 2'd2};
      vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h1220,  2, 0, 0, 0,  3,  2, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h1,   2'd0};
      vecs[9]  = '{64'h500, 80'h10,                    1, 0, 0, 0,  2,  1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h501, 2'd0};
      vecs[10] = '{64'h600, 80'h807060504030201080,    9, 1, 0, 0, 19,  9, 4'h8, 4'h0, 4'hF, 4'hF, 64'h8070605040302010, 64'h609, 2'd0};
      vecs[11] = '{64'h700, 80'h1122334455667788F330, 10, 0, 1, 0,  2,  1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h701, 2'd2};
      vecs[12] = '{64'h800, 80'h91,                    1, 0, 0, 0,  2,  1, 4'h9, 4'h1, 4'hF, 4'hF, 64'h0, 64'h801, 2'd3};
      vecs[13] = '{64'h900, 80'hA8A7A6A5A4A3A2A16750, 10, 0, 1, 9, 11, 10, 4'h5, 4'h0, 4'h6, 4'h7, 64'h00A7A6A5A4A3A2A1, 64'h90A, 2'd2};
      vecs[14] = '{64'hA00, 80'h00,                    1, 0, 1, 0,  2,  1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hA01, 2'd2};
      vecs[15] = '{64'hB00, 80'h27,                    1, 0, 0, 0,  2,  1, 4'h2, 4'h7, 4'hF, 4'hF, 64'h0, 64'hB01, 2'd3};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",    64'(bus.mem_req), 64'd0);
      chk("rst_addr",   bus.mem_addr,     64'd0);
      chk("rst_busy",   64'(busy),        64'd0);
      chk("rst_done",   64'(done),        64'd0);
      chk("rst_icode",  64'(icode),       64'd0);
      chk("rst_rA",     64'(rA),          64'hF);
      chk("rst_rB",     64'(rB),          64'hF);
      chk("rst_valP",   valP,             64'd0);
      chk("rst_status", 64'(status),      64'd0);
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors
      for (int v = 0; v < NV; v++) begin
         load_img(vecs[v].pc, vecs[v].code, vecs[v].nb);
         wait_cyc = vecs[v].wt;
         err_en   = vecs[v].erre;
         err_addr = vecs[v].pc + 64'(vecs[v].erri);
         base = n_acks;
         hv0  = hold_viol;
         run_fetch(vecs[v].pc, lat);
         chk($sformatf("v%0d_lat",    v), 64'(lat),    64'(vecs[v].lat));
         chk($sformatf("v%0d_icode",  v), 64'(icode),  64'(vecs[v].icode));
         chk($sformatf("v%0d_ifun",   v), 64'(ifun),   64'(vecs[v].ifun));
         chk($sformatf("v%0d_rA",     v), 64'(rA),     64'(vecs[v].ra));
         chk($sformatf("v%0d_rB",     v), 64'(rB),     64'(vecs[v].rb));
         chk($sformatf("v%0d_valC",   v), valC,        vecs[v].valc);
         chk($sformatf("v%0d_valP",   v), valP,        vecs[v].valp);
         chk($sformatf("v%0d_status", v), 64'(status), 64'(vecs[v].st));
         chk($sformatf("v%0d_acks",   v), 64'(n_acks - base), 64'(vecs[v].nacks));
         chk($sformatf("v%0d_busy",   v), 64'(busy),   64'd0);
         chk($sformatf("v%0d_req",    v), 64'(bus.mem_req), 64'd0);
         chk($sformatf("v%0d_hold",   v), 64'(hold_viol - hv0), 64'd0);
         n = (n_acks - base < vecs[v].nacks) ? n_acks - base : vecs[v].nacks;
         for (int i = 0; i < n; i++)
            chk($sformatf("v%0d_addr%0d", v, i), acked_addr[(base + i) & 255], vecs[v].pc + 64'(i));
         // done is a single pulse and results hold afterwards
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pulse", v), 64'(done), 64'd0);
         chk($sformatf("v%0d_holdP", v), valP,      vecs[v].valp);
      end

      // start while busy is ignored
      load_img(64'h100, vecs[0].code, 10);
      wait_cyc = 0;
      err_en = 1'b0;
      base = n_acks;
      @(negedge clk);
      pc = 64'h100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      pc = 64'h999;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("busy_start_done",  64'(done),   64'd1);
      chk("busy_start_valP",  valP,        64'h10A);
      chk("busy_start_valC",  valC,        64'h1122334455667788);
      chk("busy_start_acks",  64'(n_acks - base), 64'd10);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_start_idle",  64'(busy),   64'd0);

      // reset in the middle of an irmov fetch
      @(negedge clk);
      pc = 64'h100;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_req_before", 64'(bus.mem_req), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_req",    64'(bus.mem_req), 64'd0);
      chk("mid_busy",   64'(busy),        64'd0);
      chk("mid_done",   64'(done),        64'd0);
      chk("mid_addr",   bus.mem_addr,     64'd0);
      chk("mid_icode",  64'(icode),       64'd0);
      chk("mid_ifun",   64'(ifun),        64'd0);
      chk("mid_rA",     64'(rA),          64'hF);
      chk("mid_rB",     64'(rB),          64'hF);
      chk("mid_valC",   valC,             64'd0);
      chk("mid_valP",   valP,             64'd0);
      chk("mid_status", 64'(status),      64'd0);
      @(negedge clk);
      rst = 1'b0;
      load_img(64'h40, 80'h00, 1);
      run_fetch(64'h40, lat);
      chk("post_rst_lat",    64'(lat),    64'd2);
      chk("post_rst_valP",   valP,        64'h41);
      chk("post_rst_status", 64'(status), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
